// File: rtl/spline_interp_eval.sv
// Spline evaluator: y = sat(round(sum_k u[k]*q[j+k]) >> QP) over a
// clamped span j, with a writable bank of Q control points.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready, u_vec_C_packed, span_ind : basis vector and span in
//   out_valid/out_ready, y_out, span_out, span_oob : result out
//   cp_we, cp_addr, cp_wdata : control-point write port
module spline_interp_eval #(
   parameter int WIDTH      = 16,
   parameter int Q_ORD      = 4,
   parameter int QP         = 12,
   parameter int Q          = 13,
   parameter int DelX_inv   = 2,
   parameter int SPAN_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [Q_ORD*WIDTH-1:0]   u_vec_C_packed,
   input  logic [SPAN_WIDTH-1:0]    span_ind,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         y_out,
   output logic [SPAN_WIDTH-1:0]    span_out,
   output logic                     span_oob,
   input  logic                     cp_we,
   input  logic [SPAN_WIDTH-1:0]    cp_addr,
   input  logic [WIDTH-1:0]         cp_wdata
);

   localparam int KW   = (Q_ORD > 1) ? $clog2(Q_ORD) : 1;
   localparam int AW   = 2*WIDTH + 2;
   localparam int JMAX = Q - Q_ORD;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MAC  = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;

   localparam logic signed [AW:0] RND_C = (AW+1)'(1 << (QP-1));
   localparam logic signed [AW:0] Y_MAX = (AW+1)'((1 << (WIDTH-1)) - 1);
   localparam logic signed [AW:0] Y_MIN = (AW+1)'(-(1 << (WIDTH-1)));

   logic [1:0]                state;
   logic [KW-1:0]             k;
   logic [Q_ORD*WIDTH-1:0]    u_reg;
   logic signed [AW-1:0]      acc;
   logic signed [WIDTH-1:0]   q [Q];

   logic                      oob_c;
   logic [SPAN_WIDTH-1:0]     j_c;
   logic [SPAN_WIDTH:0]       idx;
   logic signed [WIDTH-1:0]   cp_sel;
   logic signed [WIDTH-1:0]   u_sel;
   logic signed [2*WIDTH-1:0] prod;
   logic signed [AW-1:0]      acc_nxt;
   logic signed [AW:0]        rnd;
   logic signed [AW:0]        shf;
   logic [WIDTH-1:0]          y_sat;
   logic                      cp_wr_ok;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == OUT);

   assign oob_c = ({1'b0, span_ind} > (SPAN_WIDTH+1)'(JMAX));
   assign j_c   = oob_c ? SPAN_WIDTH'(JMAX) : span_ind;

   // span_out doubles as the registered base index j
   assign idx = {1'b0, span_out} + (SPAN_WIDTH+1)'(k);

   always_comb begin
      cp_sel = '0;
      for (int i = 0; i < Q; i++)
         if (idx == (SPAN_WIDTH+1)'(i))
            cp_sel = q[i];
   end

   always_comb begin
      u_sel = '0;
      for (int i = 0; i < Q_ORD; i++)
         if (k == KW'(i))
            u_sel = u_reg[WIDTH*i +: WIDTH];
   end

   assign prod    = u_sel * cp_sel;
   assign acc_nxt = acc + AW'(prod);

   // round half up, then arithmetic shift; one extra bit keeps the
   // rounding add from wrapping
   assign rnd = (AW+1)'(acc_nxt) + RND_C;
   assign shf = rnd >>> QP;

   always_comb begin
      y_sat = shf[WIDTH-1:0];
      if (shf > Y_MAX)
         y_sat = Y_MAX[WIDTH-1:0];
      else if (shf < Y_MIN)
         y_sat = Y_MIN[WIDTH-1:0];
   end

   assign cp_wr_ok = cp_we &&
      ({1'b0, cp_addr} < (SPAN_WIDTH+1)'(Q));

   // control points reset to an identity line centred on the middle index
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < Q; i++)
            q[i] <= WIDTH'((i - (Q+1)/2) * (1 << (QP-DelX_inv)));
      end else begin
         for (int i = 0; i < Q; i++)
            if (cp_wr_ok && cp_addr == SPAN_WIDTH'(i))
               q[i] <= cp_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         k        <= '0;
         u_reg    <= '0;
         acc      <= '0;
         y_out    <= '0;
         span_out <= '0;
         span_oob <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  u_reg    <= u_vec_C_packed;
                  span_out <= j_c;
                  span_oob <= oob_c;
                  acc      <= '0;
                  k        <= '0;
                  state    <= MAC;
               end
            end
            MAC: begin
               acc <= acc_nxt;
               if (k == KW'(Q_ORD-1)) begin
                  y_out <= y_sat;
                  state <= OUT;
               end else begin
                  k <= k + KW'(1);
               end
            end
            OUT: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spline_interp_eval.sv
// Directed bench for spline_interp_eval: behavioural model plus
// per-cycle output compare and literal expectations.
module tb_spline_interp_eval;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] u_vec_C_packed;
   logic [4:0]  span_ind;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] y_out;
   logic [4:0]  span_out;
   logic        span_oob;
   logic        cp_we;
   logic [4:0]  cp_addr;
   logic [15:0] cp_wdata;

   always #5 clk = ~clk;

   spline_interp_eval dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .u_vec_C_packed (u_vec_C_packed),
      .span_ind       (span_ind),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .y_out          (y_out),
      .span_out       (span_out),
      .span_oob       (span_oob),
      .cp_we          (cp_we),
      .cp_addr        (cp_addr),
      .cp_wdata       (cp_wdata)
   );

   typedef struct {
      int y;
      int sp;
      int oob;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   int   mq [13];
   exp_t expq [$];

   task automatic check(string nm, int act, int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   function automatic void mq_reset();
      for (int i = 0; i < 13; i++)
         mq[i] = (i - 7) * 1024;
   endfunction

   function automatic exp_t model(int u0, int u1, int u2, int u3, int sp);
      exp_t   e;
      int     j;
      int     u [4];
      longint acc;
      longint r;
      u[0] = u0; u[1] = u1; u[2] = u2; u[3] = u3;
      j = (sp > 9) ? 9 : sp;
      acc = 0;
      for (int t = 0; t < 4; t++)
         acc += longint'(u[t]) * longint'(mq[j+t]);
      r = (acc + 2048) >>> 12;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      e.y = int'(r);
      e.sp = j;
      e.oob = (sp > 9) ? 1 : 0;
      return e;
   endfunction

   always @(negedge clk) begin
      if (reset === 1'b1 && out_valid === 1'b1) begin
         if (expq.size() == 0) begin
            check("spurious_out_valid", 1, 0);
         end else begin
            check("y_out", int'($signed(y_out)), expq[0].y);
            check("span_out", int'(span_out), expq[0].sp);
            check("span_oob", int'(span_oob), expq[0].oob);
            if (out_ready)
               void'(expq.pop_front());
         end
      end
   end

   task automatic send(int u0, int u1, int u2, int u3, int sp);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready)
         check("send_timeout", 0, 1);
      u_vec_C_packed = {16'(u3), 16'(u2), 16'(u1), 16'(u0)};
      span_ind = 5'(sp);
      in_valid = 1'b1;
      expq.push_back(model(u0, u1, u2, u3, sp));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((expq.size() != 0 || !in_ready) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_timeout", expq.size(), 0);
   endtask

   task automatic eval_lit(int u0, int u1, int u2, int u3, int sp,
                           int ey, string nm);
      send(u0, u1, u2, u3, sp);
      drain();
      check(nm, int'($signed(y_out)), ey);
   endtask

   task automatic cp_write(int a, int d);
      cp_we = 1'b1;
      cp_addr = 5'(a);
      cp_wdata = 16'(d);
      @(posedge clk); #1;
      cp_we = 1'b0;
      if (a < 13)
         mq[a] = d;
   endtask

   initial begin
      int first;
      int nlow;
      int n;
      reset = 1'b0;
      in_valid = 1'b0;
      u_vec_C_packed = '0;
      span_ind = '0;
      out_ready = 1'b1;
      cp_we = 1'b0;
      cp_addr = '0;
      cp_wdata = '0;
      mq_reset();

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_y_out", int'(y_out), 0);
      check("rst_span_out", int'(span_out), 0);
      check("rst_span_oob", int'(span_oob), 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // first transaction: latency and busy window
      send(0, 4096, 0, 0, 6);
      first = -1;
      nlow = in_ready ? 0 : 1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid && first < 0)
            first = i;
         if (!in_ready)
            nlow++;
         else
            break;
      end
      check("latency", first, 4);
      check("in_ready_low_cycles", nlow, 5);
      drain();
      check("lit_span6", int'($signed(y_out)), 0);
      check("lit_span6_oob", int'(span_oob), 0);

      eval_lit(0, 4096, 0, 0, 8, 2048, "lit_span8");
      eval_lit(0, 4096, 0, 0, 12, 3072, "lit_span12");
      check("lit_span12_out", int'(span_out), 9);
      check("lit_span12_oob", int'(span_oob), 1);

      // saturation both ways
      for (int i = 0; i < 4; i++)
         cp_write(i, 32767);
      eval_lit(4096, 4096, 4096, 4096, 0, 32767, "lit_sat_pos");
      for (int i = 0; i < 4; i++)
         cp_write(i, -32768);
      eval_lit(4096, 4096, 4096, 4096, 0, -32768, "lit_sat_neg");

      // back-pressure: hold outputs, ignore in_valid
      out_ready = 1'b0;
      send(0, 0, 4096, 2048, 5);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("hold_reach_out", int'(out_valid), 1);
      for (int i = 0; i < 3; i++) begin
         u_vec_C_packed = {16'd0, 16'd0, 16'd0, 16'd4096};
         span_ind = 5'd1;
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         check("hold_in_ready", int'(in_ready), 0);
         check("hold_out_valid", int'(out_valid), 1);
         check("hold_y", int'($signed(y_out)), 512);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("hs_out_valid", int'(out_valid), 0);
      check("hs_in_ready", int'(in_ready), 1);
      repeat (6) @(posedge clk);
      #1;
      check("hs_no_extra", expq.size(), 0);

      // write during MAC uses old value, then new value
      send(0, 4096, 0, 0, 6);
      @(posedge clk); #1;
      cp_we = 1'b1;
      cp_addr = 5'd7;
      cp_wdata = 16'd500;
      @(posedge clk); #1;
      cp_we = 1'b0;
      mq[7] = 500;
      drain();
      check("lit_pre_write", int'($signed(y_out)), 0);
      eval_lit(0, 4096, 0, 0, 6, 500, "lit_post_write");
      eval_lit(0, 2049, 0, 0, 6, 250, "lit_round");
      cp_write(20, 12345);
      cp_write(13, 12345);
      eval_lit(4096, 4096, 4096, 4096, 9, 14336, "lit_oob_write");

      // mixed vectors against the model
      for (int i = 0; i < 6; i++) begin
         send(int'($urandom_range(8192, 0)) - 4096,
              int'($urandom_range(8192, 0)) - 4096,
              int'($urandom_range(8192, 0)) - 4096,
              int'($urandom_range(8192, 0)) - 4096,
              int'($urandom_range(15, 0)));
         drain();
      end

      // reset during the second MAC cycle
      send(4096, 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      expq.delete();
      mq_reset();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("mid_rst_out_valid", int'(out_valid), 0);
         check("mid_rst_in_ready", int'(in_ready), 1);
      end
      reset = 1'b1;
      nlow = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid)
            nlow++;
      end
      check("post_rst_no_out", nlow, 0);
      eval_lit(0, 4096, 0, 0, 6, 0, "lit_rst_q7");
      eval_lit(4096, 0, 0, 0, 0, -7168, "lit_rst_q0");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/spline_interp_eval.md
SPLINE_INTERP_EVAL -- requirements
Module: spline_interp_eval

Interface
Parameters:
REQ-001 SHALL have parameter WIDTH, default 16: sample, control-point and basis-coefficient width, signed two's complement.
REQ-002 SHALL have parameter Q_ORD, default 4: number of basis coefficients per evaluation.
REQ-003 SHALL have parameter QP, default 12: fractional bits of all fixed-point quantities.
REQ-004 SHALL have parameter Q, default 13: number of control points.
REQ-005 SHALL have parameter DelX_inv, default 2: log2 of 1/DelX, used only for control-point reset values.
REQ-006 SHALL have parameter SPAN_WIDTH, default 5: span index width.

Ports:
REQ-007 SHALL have port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-009 SHALL have port in_valid, input, 1, basis vector and span are presented.
REQ-010 SHALL have port in_ready, output, 1, block can accept an input.
REQ-011 SHALL have port u_vec_C_packed, input, Q_ORD*WIDTH, coefficient k in bits [WIDTH*k +: WIDTH].
REQ-012 SHALL have port span_ind, input, SPAN_WIDTH, unsigned span index j.
REQ-013 SHALL have port out_valid, output, 1, y_out is valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts y_out.
REQ-015 SHALL have port y_out, output, WIDTH, interpolated sample.
REQ-016 SHALL have port span_out, output, SPAN_WIDTH, clamped span used for y_out.
REQ-017 SHALL have port span_oob, output, 1, span_ind was clamped.
REQ-018 SHALL have port cp_we, input, 1, control-point write strobe.
REQ-019 SHALL have port cp_addr, input, SPAN_WIDTH, control-point write address.
REQ-020 SHALL have port cp_wdata, input, WIDTH, control-point write data.

Function
REQ-021 SHALL implement FSM states IDLE, MAC and OUT, with in_ready = 1 only in IDLE.
REQ-022 SHALL, in IDLE with in_valid=1, register u_vec_C_packed and the clamped span, clear the accumulator and k, and enter MAC.
REQ-023 SHALL clamp span as follows: j = min(span_ind, Q-Q_ORD); span_oob = (span_ind > Q-Q_ORD), registered together with span_out.
REQ-024 SHALL, in MAC, add one product u_vec_C[k]*q[j+k] per cycle for k = 0..Q_ORD-1, with a signed accumulator of 2*WIDTH+2 bits.
REQ-025 SHALL, on the edge adding k = Q_ORD-1, load y_out = sat_WIDTH((acc_final + 2^(QP-1)) >>> QP) and enter OUT.
REQ-026 SHALL produce out_valid high in the cycle after that edge, i.e. Q_ORD cycles after the accept edge.
REQ-027 SHALL, in OUT, hold y_out, span_out, span_oob and out_valid stable until out_valid & out_ready, then return to IDLE on that edge.
REQ-028 SHALL give in_valid no effect outside IDLE; there is no same-cycle OUT-to-accept bypass.
REQ-029 SHALL store Q control points q[0..Q-1] of WIDTH bits each in registers.
REQ-030 SHALL write cp_wdata to q[cp_addr] on the edge when cp_we=1 and cp_addr < Q; writes with cp_addr >= Q SHALL be ignored.
REQ-031 SHALL accept writes in any state, with a MAC read in the same cycle using the pre-write value.
REQ-032 SHALL saturate y_out to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; the accumulator SHALL never wrap.

Reset
REQ-033 SHALL, while reset=0, force state IDLE, in_ready=1, out_valid=0, y_out=0, span_out=0, span_oob=0 and accumulator=0.
REQ-034 SHALL, while reset=0, set q[i] = (i-(Q+1)/2) * 2^(QP-DelX_inv), which is (i-7)*1024 at defaults (identity line).
REQ-035 SHALL abort any in-progress MAC or OUT transaction on reset assertion, producing no output.

Verification
REQ-036 SHALL cover: after reset, u_vec=(0,4096,0,0), span 6, out_ready=1 -> in_ready low 5 cycles, out_valid pulses 4 cycles after accept, y_out=0, span_oob=0.
REQ-037 SHALL cover: span 8, u_vec=(0,4096,0,0) -> y_out=2048; span 12 -> span_out=9, span_oob=1, y_out=3072.
REQ-038 SHALL cover: write q[0..3]=32767, span 0, u_vec=(4096,4096,4096,4096) -> y_out=32767 (saturated); same data with -32768 -> y_out=-32768.
REQ-039 SHALL cover: out_ready low 3 cycles in OUT -> y_out and out_valid held; in_valid pulses ignored; a single handshake then returns to IDLE.
REQ-040 SHALL cover: cp_we to q[7]=500 during the MAC cycle reading q[7] -> old value used; the next evaluation uses 500; cp_addr=20 leaves all q unchanged.
REQ-041 SHALL cover: reset asserted in the 2nd MAC cycle -> out_valid stays 0, in_ready=1, q restored to defaults, and the next transaction is correct.
